sram_wb_bridge: RTL and testbench

SRAM_WB_BRIDGE -- requirements
Module: sram_wb_bridge

---
 rtl/sram_wb_bridge.sv | 75 +++++++
 tb/tb_sram_wb_bridge.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/sram_wb_bridge.sv
// sram_wb_bridge: Wishbone slave bridging a 2 KB address window onto a single-port SRAM macro.
module sram_wb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_F800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        sram_clk0,
  output logic        sram_csb0,
  output logic        sram_web0,
  output logic [3:0]  sram_wmask0,
  output logic [8:0]  sram_addr0,
  output logic [31:0] sram_din0,
  input  logic [31:0] sram_dout0
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_ERR} state_t;
  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] dat_q, dat_d;
  logic        req, hit, access, live;
  assign sram_clk0 = clk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
    end
  // rst_n gates the request so the SRAM stays deselected while reset is held
  always_comb begin
    req    = rst_n & wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
    hit    = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
    live   = wbs_cyc_i & wbs_stb_i;
    access = (state_q == S_IDLE) & req & hit;
  end
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    dat_d   = dat_q;
    case (state_q)
      S_IDLE: if (req) begin
        state_d = hit ? S_WAIT : S_ERR;
        we_d    = wbs_we_i;
        dat_d   = hit ? dat_q : '0;
      end
      S_WAIT: begin
        state_d = live ? S_ACK : S_IDLE;
        dat_d   = live ? (we_q ? '0 : sram_dout0) : dat_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    wbs_ack_o   = state_q == S_ACK;
    wbs_err_o   = state_q == S_ERR;
    wbs_dat_o   = dat_q;
    sram_csb0   = ~access;
    sram_web0   = access ? ~wbs_we_i : 1'b1;
    sram_wmask0 = (access & wbs_we_i) ? wbs_sel_i : 4'b0;
    sram_addr0  = access ? wbs_adr_i[10:2] : 9'd0;
    sram_din0   = access ? wbs_dat_i : 32'd0;
  end
endmodule

// File: tb/tb_sram_wb_bridge.sv
// tb_sram_wb_bridge: randomized Wishbone traffic against a word-array reference of the SRAM window.
module tb_sram_wb_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] MASK = 32'hFFFF_F800;
  logic        clk = 0, rst_n = 0;
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] adr = 0, dat = 0;
  logic        ack, err, sclk, csb, web;
  logic [31:0] dat_o, din, dout;
  logic [3:0]  wmask;
  logic [8:0]  saddr;
  logic [31:0] mem [512] = '{default: 32'd0};
  logic [31:0] ref_mem [512] = '{default: 32'd0};
  logic [31:0] exp_dat = 0;
  int          n_chk = 0, n_fail = 0;

  sram_wb_bridge dut (
    .clk(clk), .rst_n(rst_n), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack),
    .wbs_err_o(err), .wbs_dat_o(dat_o), .sram_clk0(sclk), .sram_csb0(csb),
    .sram_web0(web), .sram_wmask0(wmask), .sram_addr0(saddr), .sram_din0(din),
    .sram_dout0(dout)
  );

  always #5 clk = ~clk;

  always @(posedge sclk)
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][8*b +: 8] <= din[8*b +: 8];
      end else dout <= mem[saddr];
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge with the bridge idle.
  task automatic xact(input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input bit abort);
    bit h;
    logic [8:0] wa;
    h  = (a & MASK) == BASE;
    wa = a[10:2];
    check("idle_ack", ack, 0);
    check("idle_err", err, 0);
    check("dat_hold", dat_o, exp_dat);
    cyc = 1; stb = 1; we = w; sel = s; adr = a; dat = d;
    #1;
    check("c0_csb", csb, !h);
    if (h) begin
      check("c0_web", web, !w);
      check("c0_wmask", wmask, w ? s : 4'h0);
      check("c0_addr", saddr, wa);
      check("c0_din", din, d);
    end
    @(negedge clk);
    if (!h) begin
      check("err_c1", err, 1);
      check("err_noack", ack, 0);
      check("err_csb", csb, 1);
      check("err_dat", dat_o, 0);
      exp_dat = 0;
      cyc = 0; stb = 0;
      @(negedge clk);
    end else begin
      check("c1_ack", ack, 0);
      check("c1_err", err, 0);
      check("c1_csb", csb, 1);
      if (w)
        for (int b = 0; b < 4; b++)
          if (s[b]) ref_mem[wa][8*b +: 8] = d[8*b +: 8];
      if (abort) begin
        cyc = 0; stb = 0;
        @(negedge clk);
        check("abort_ack", ack, 0);
        check("abort_csb", csb, 1);
      end else begin
        @(negedge clk);
        check("c2_ack", ack, 1);
        check("c2_err", err, 0);
        check("c2_csb", csb, 1);
        exp_dat = w ? 32'd0 : ref_mem[wa];
        check("c2_dat", dat_o, exp_dat);
        cyc = 0; stb = 0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    cyc = 1; stb = 1; adr = 32'h3000_0010;
    #1;
    check("rst_csb", csb, 1);
    check("rst_web", web, 1);
    check("rst_wmask", wmask, 0);
    check("rst_addr", saddr, 0);
    check("rst_din", din, 0);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_dat", dat_o, 0);
    cyc = 0; stb = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    xact(1, 4'hF, 32'h3000_0010, 32'hDEADBEEF, 0);
    xact(0, 4'hF, 32'h3000_0010, 32'h0, 0);
    check("rd_deadbeef", exp_dat, 32'hDEADBEEF);
    xact(1, 4'h1, 32'h3000_0010, 32'h0000_0055, 0);
    xact(0, 4'hF, 32'h3000_0013, 32'h0, 0);
    check("rd_merge", exp_dat, 32'hDEADBE55);
    xact(1, 4'h0, 32'h3000_0010, 32'h1234_5678, 0);
    xact(0, 4'hF, 32'h3000_0010, 32'h0, 0);
    xact(0, 4'hF, 32'h3000_0800, 32'h0, 0);
    xact(0, 4'hF, 32'h3000_0010, 32'h0, 1);
    xact(0, 4'hF, 32'h3000_07FC, 32'h0, 0);
    // Reset pulse while the read sits in WAIT.
    cyc = 1; stb = 1; we = 0; sel = 4'hF; adr = 32'h3000_0010;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("rstw_csb", csb, 1);
    check("rstw_ack", ack, 0);
    check("rstw_dat", dat_o, 0);
    @(negedge clk);
    check("rstw_ack2", ack, 0);
    check("rstw_csb2", csb, 1);
    cyc = 0; stb = 0; rst_n = 1; exp_dat = 0;
    xact(0, 4'hF, 32'h3000_0010, 32'h0, 0);
    check("post_rst_rd", exp_dat, 32'hDEADBE55);
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      bit hit_sel;
      hit_sel = $urandom_range(0, 3) != 0;
      a = hit_sel ? (BASE | $urandom_range(0, 2047)) : $urandom;
      xact($urandom_range(0, 1) == 1, 4'($urandom), a, $urandom, $urandom_range(0, 7) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
